imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parameterised immediate generator for the decode stage of the RISC-V core. It covers all RV32I/RV64I immediate formats (I, S, B, U, J, shift-amount) and sign-extends to XLEN. Instruction and sideband tag pass through a registered output stage with a 2-entry skid buffer and valid/ready handshakes on both sides. It also flags unsupported opcodes and keeps a saturating illegal-instruction counter.

## Interface
- XLEN, 32: immediate output width; legal values 32 or 64.
- TAG_W, 32: width of the pass-through sideband (typically PC).
- CNT_W, 16: width of the illegal-instruction counter.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  block can accept input.
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts output.
- out_imm  out  XLEN  generated immediate.
- out_fmt  out  3  format: 0 none (R-type), 1 I, 2 S, 3 B, 4 U, 5 J, 6 shamt, 7 illegal.
- out_illegal  out  1  opcode not supported.
- out_instr  out  32  instruction, passed through.
- out_tag  out  TAG_W  tag, passed through.
- illegal_cnt  out  CNT_W  count of accepted illegal instructions, saturating.

## Operation
- Decode (combinational, from in_instr[6:0]):
  - 0000011, 1100111, 1110011, and 0010011 with funct3 not 001/101 are I-type: imm = sext(instr[31:20]).
  - 0010011 with funct3 001/101 is shamt: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - 0100011 is S-type: sext({instr[31:25], instr[11:7]}).
  - 1100011 is B-type: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111 and 0010111 are U-type: sext({instr[31:12], 12'b0}).
  - 1101111 is J-type: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110011 is R-type: fmt 0, imm 0.
  - Any other opcode: fmt 7, imm 0, illegal 1.
- Storage:
  - Main output register (M) and skid register (K), each with its own valid bit.
  - in_ready = !K.valid, registered-derived, with no combinational path from out_ready.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_valid = M.valid.
- Per-cycle update (no flush):
  - M empty or out_fire, K valid: K moves to M. If in_fire, the new entry goes to K.
  - M empty or out_fire, K empty: if in_fire, the new entry goes to M; otherwise M.valid clears.
  - M full and not out_fire: if in_fire, the new entry goes to K.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- flush: clears M.valid and K.valid at the next edge. A same-cycle in_fire is discarded and does not count. Data registers may hold stale values.
- illegal_cnt increments on in_fire of an illegal opcode when flush=0. It saturates at 2^CNT_W−1 and does not wrap.
- Output data registers do not change while out_valid & !out_ready.

## Timing
- Latency: in_fire in cycle N gives out_valid in cycle N+1 when M is empty or draining.
- Throughput: 1 instruction/cycle under continuous out_ready.
- Buffering: with out_ready low, 2 entries are accepted. in_ready falls the cycle after K fills and rises the cycle after K drains.
- Reset (asynchronous, immediate):
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_instr=0, out_tag=0, illegal_cnt=0.
  - Both valid bits are 0, so in_ready=1 while reset is asserted and afterwards.
- Reset mid-transfer: all buffered entries are lost and no output fires.
- flush and reset together: reset wins.

## Test plan
- I/S, XLEN=32: in_instr 0xFFF00093 (addi x1,x0,-1) then 0x0020A423 (sw x2,8(x1)) with out_ready=1 -> next cycles out_imm 0xFFFFFFFF fmt 1, then 0x00000008 fmt 2, back-to-back.
- B/U/J: 0xFE000EE3 -> 0xFFFFFFFC fmt 3; 0x123450B7 -> 0x12345000 fmt 4; 0x001000EF -> 0x00000800 fmt 5.
- XLEN=64: 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF. 0x03F09093 (slli x1,x1,63) -> 0x3F fmt 6.
- Backpressure: out_ready=0, in_valid=1 with tags 1,2,3 -> tags 1,2 accepted, in_ready=0, tag 3 held. Raise out_ready -> outputs in order 1,2,3, one per cycle.
- Flush: two entries buffered, flush=1 with in_valid=1 -> out_valid=0 next cycle, in_ready=1, nothing emitted afterwards.
- Illegal: CNT_W=2, five accepted 0x0000007F -> out_illegal=1 fmt 7 imm 0 each. illegal_cnt goes 1,2,3,3,3. Assert reset mid-stream -> counter 0 and out_valid 0 immediately.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a registered output stage and a
// 2-entry skid buffer (main register M, skid register K).
// Also flags unsupported opcodes and counts them with a saturating counter.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int EW = XLEN + 3 + 1 + 32 + TAG_W;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_SH  = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // ---- stage p0: combinational decode of the incoming instruction ----
  logic [6:0]              opc_p0;
  logic [2:0]              f3_p0;
  logic signed [11:0]      imm_i_p0;
  logic signed [11:0]      imm_s_p0;
  logic signed [12:0]      imm_b_p0;
  logic signed [31:0]      imm_u_p0;
  logic signed [20:0]      imm_j_p0;
  logic signed [XLEN-1:0]  imm_p0;
  logic [2:0]              fmt_p0;
  logic                    ill_p0;
  logic [EW-1:0]           ent_p0;

  assign opc_p0   = in_instr[6:0];
  assign f3_p0    = in_instr[14:12];
  assign imm_i_p0 = in_instr[31:20];
  assign imm_s_p0 = {in_instr[31:25], in_instr[11:7]};
  assign imm_b_p0 = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u_p0 = {in_instr[31:12], 12'b0};
  assign imm_j_p0 = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // Select format and sign-extended immediate from the opcode.
  always_comb begin
    imm_p0 = '0;
    fmt_p0 = FMT_R;
    ill_p0 = 1'b0;
    case (opc_p0)
      7'b0000011, 7'b1100111, 7'b1110011: begin
        imm_p0 = XLEN'(imm_i_p0);
        fmt_p0 = FMT_I;
      end
      7'b0010011: begin
        if (f3_p0 == 3'b001 || f3_p0 == 3'b101) begin
          // Shift amount is zero-extended; RV64 uses one extra bit.
          if (XLEN == 64) imm_p0 = XLEN'(in_instr[25:20]);
          else            imm_p0 = XLEN'(in_instr[24:20]);
          fmt_p0 = FMT_SH;
        end else begin
          imm_p0 = XLEN'(imm_i_p0);
          fmt_p0 = FMT_I;
        end
      end
      7'b0100011: begin
        imm_p0 = XLEN'(imm_s_p0);
        fmt_p0 = FMT_S;
      end
      7'b1100011: begin
        imm_p0 = XLEN'(imm_b_p0);
        fmt_p0 = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        imm_p0 = XLEN'(imm_u_p0);
        fmt_p0 = FMT_U;
      end
      7'b1101111: begin
        imm_p0 = XLEN'(imm_j_p0);
        fmt_p0 = FMT_J;
      end
      7'b0110011: begin
        fmt_p0 = FMT_R;
      end
      default: begin
        fmt_p0 = FMT_ILL;
        ill_p0 = 1'b1;
      end
    endcase
  end

  assign ent_p0 = {imm_p0, fmt_p0, ill_p0, in_instr, in_tag};

  // ---- stage p1: output register M and skid register K ----
  logic          m_vld_p1;
  logic          k_vld_p1;
  logic [EW-1:0] m_ent_p1;
  logic [EW-1:0] k_ent_p1;
  logic          in_fire;
  logic          m_take;
  logic          m_load;
  logic          k_load;

  // in_ready depends only on K's valid bit, so out_ready never reaches it.
  assign in_ready = !k_vld_p1;
  assign in_fire  = in_valid && in_ready;
  // M can be overwritten when it is empty or its entry leaves this cycle.
  assign m_take   = !m_vld_p1 || out_ready;
  assign m_load   = !flush && m_take && (k_vld_p1 || in_fire);
  assign k_load   = !flush && in_fire && !m_take;

  // Valid bits and illegal counter; flush kills both entries and the input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_vld_p1    <= 1'b0;
      k_vld_p1    <= 1'b0;
      illegal_cnt <= '0;
    end else if (flush) begin
      m_vld_p1 <= 1'b0;
      k_vld_p1 <= 1'b0;
    end else begin
      if (m_take) begin
        m_vld_p1 <= k_vld_p1 || in_fire;
        k_vld_p1 <= k_vld_p1 && in_fire;
      end else begin
        k_vld_p1 <= k_vld_p1 || in_fire;
      end
      if (in_fire && ill_p0) illegal_cnt <= sat_inc(illegal_cnt);
    end
  end

  // M data: refilled from K first to keep FIFO order, else from the input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ent_p1 <= '0;
    end else if (m_load) begin
      m_ent_p1 <= k_vld_p1 ? k_ent_p1 : ent_p0;
    end
  end

  // K data: captures the input only while M is stalled.
  always_ff @(posedge clk) begin
    if (k_load) k_ent_p1 <= ent_p0;
  end

  assign out_valid = m_vld_p1;
  assign {out_imm, out_fmt, out_illegal, out_instr, out_tag} = m_ent_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit instance with a 2-bit counter and a
// 64-bit instance, driven in parallel and compared with a queue model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, ins32, tag32;
  logic [2:0]  fmt32;
  logic [1:0]  cnt32;

  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [31:0] ins64, tag64;
  logic [2:0]  fmt64;
  logic [15:0] cnt64;

  int checks   = 0;
  int failures = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(2)) u32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_instr(ins32),
    .out_tag(tag32), .illegal_cnt(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(16)) u64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_instr(ins64),
    .out_tag(tag64), .illegal_cnt(cnt64)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] instr;
    logic [31:0] tag;
  } ent_t;

  ent_t q32[$];
  ent_t q64[$];
  int   mcnt32 = 0;
  int   mcnt64 = 0;

  // Reference decode built from the bit-field weights of each format.
  function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] tg, input int xl);
    ent_t   e;
    longint v;
    logic [6:0] opc;
    logic [2:0] f3;
    opc = ins[6:0];
    f3  = ins[14:12];
    v = 0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    case (opc)
      7'b0000011, 7'b1100111, 7'b1110011: begin
        v = longint'(ins[31:20]); if (ins[31]) v -= 4096; e.fmt = 3'd1;
      end
      7'b0010011: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          v = (xl == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
          e.fmt = 3'd6;
        end else begin
          v = longint'(ins[31:20]); if (ins[31]) v -= 4096; e.fmt = 3'd1;
        end
      end
      7'b0100011: begin
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (ins[31]) v -= 4096; e.fmt = 3'd2;
      end
      7'b1100011: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (ins[31]) v -= 8192; e.fmt = 3'd3;
      end
      7'b0110111, 7'b0010111: begin
        v = longint'(ins[31:12]) * 4096;
        if (ins[31]) v -= (64'sd1 <<< 32); e.fmt = 3'd4;
      end
      7'b1101111: begin
        v = longint'(ins[31]) * (64'sd1 <<< 20) + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (ins[31]) v -= (64'sd1 <<< 21); e.fmt = 3'd5;
      end
      7'b0110011: e.fmt = 3'd0;
      default: begin e.fmt = 3'd7; e.ill = 1'b1; end
    endcase
    e.imm   = (xl == 32) ? {32'd0, v[31:0]} : v;
    e.instr = ins;
    e.tag   = tg;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  // Compare both instances' observable state against the model.
  task automatic check_all();
    chk("rdy32", 64'(rdy32), 64'(q32.size() < 2));
    chk("vld32", 64'(vld32), 64'(q32.size() > 0));
    chk("cnt32", 64'(cnt32), 64'(mcnt32));
    if (q32.size() > 0) begin
      chk("imm32", 64'(imm32), q32[0].imm);
      chk("fmt32", 64'(fmt32), 64'(q32[0].fmt));
      chk("ill32", 64'(ill32), 64'(q32[0].ill));
      chk("ins32", 64'(ins32), 64'(q32[0].instr));
      chk("tag32", 64'(tag32), 64'(q32[0].tag));
    end
    chk("rdy64", 64'(rdy64), 64'(q64.size() < 2));
    chk("vld64", 64'(vld64), 64'(q64.size() > 0));
    chk("cnt64", 64'(cnt64), 64'(mcnt64));
    if (q64.size() > 0) begin
      chk("imm64", imm64, q64[0].imm);
      chk("fmt64", 64'(fmt64), 64'(q64[0].fmt));
      chk("ill64", 64'(ill64), 64'(q64[0].ill));
      chk("ins64", 64'(ins64), 64'(q64[0].instr));
      chk("tag64", 64'(tag64), 64'(q64[0].tag));
    end
  endtask

  // One clock cycle: drive inputs, check, advance the model, wait an edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                      input logic ordy, input logic fl);
    ent_t e32, e64;
    bit   fire32, fire64, pop32, pop64;
    in_valid  = v;
    in_instr  = ins;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    check_all();
    e32 = ref_decode(ins, tg, 32);
    e64 = ref_decode(ins, tg, 64);
    fire32 = v && (q32.size() < 2);
    fire64 = v && (q64.size() < 2);
    pop32  = ordy && (q32.size() > 0);
    pop64  = ordy && (q64.size() > 0);
    if (fl) begin
      q32.delete();
      q64.delete();
    end else begin
      if (pop32) void'(q32.pop_front());
      if (pop64) void'(q64.pop_front());
      if (fire32) begin
        q32.push_back(e32);
        if (e32.ill && mcnt32 < 3) mcnt32++;
      end
      if (fire64) begin
        q64.push_back(e64);
        if (e64.ill && mcnt64 < 65535) mcnt64++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [6:0] opc_tab [11];

  initial begin
    opc_tab = '{7'b0000011, 7'b1100111, 7'b1110011, 7'b0010011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1111111};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
    #2;
    // Reset values while reset is held.
    chk("rst_imm32", 64'(imm32), 64'd0);
    chk("rst_fmt32", 64'(fmt32), 64'd0);
    chk("rst_ins32", 64'(ins32), 64'd0);
    chk("rst_tag32", 64'(tag32), 64'd0);
    chk("rst_ill32", 64'(ill32), 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    check_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed formats, back-to-back with out_ready high.
    step(1, 32'hFFF00093, 32'h10, 1, 0);
    chk("addi32", 64'(imm32), 64'hFFFFFFFF);
    chk("addi64", imm64, 64'hFFFFFFFFFFFFFFFF);
    step(1, 32'h0020A423, 32'h14, 1, 0);
    chk("sw32", 64'(imm32), 64'h8);
    chk("sw_fmt", 64'(fmt32), 64'd2);
    step(1, 32'hFE000EE3, 32'h18, 1, 0);
    chk("beq32", 64'(imm32), 64'hFFFFFFFC);
    step(1, 32'h123450B7, 32'h1C, 1, 0);
    chk("lui32", 64'(imm32), 64'h12345000);
    step(1, 32'h001000EF, 32'h20, 1, 0);
    chk("jal32", 64'(imm32), 64'h800);
    step(1, 32'h03F09093, 32'h24, 1, 0);
    chk("slli64", imm64, 64'h3F);
    chk("slli_fmt", 64'(fmt64), 64'd6);
    step(1, 32'h00208033, 32'h28, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // Backpressure: tags 1,2 accepted, tag 3 held until K drains.
    step(1, 32'h00100093, 32'd1, 0, 0);
    step(1, 32'h00200093, 32'd2, 0, 0);
    step(1, 32'h00300093, 32'd3, 0, 0);
    chk("bp_ready", 64'(rdy32), 64'd0);
    step(1, 32'h00300093, 32'd3, 0, 0);
    step(1, 32'h00300093, 32'd3, 1, 0);
    step(1, 32'h00300093, 32'd3, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // Flush with two entries buffered and an input offered.
    step(1, 32'h00500093, 32'd5, 0, 0);
    step(1, 32'h00600093, 32'd6, 0, 0);
    step(1, 32'h0000007F, 32'd7, 0, 1);
    chk("fl_vld", 64'(vld32), 64'd0);
    chk("fl_rdy", 64'(rdy32), 64'd1);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // Illegal opcodes: counter saturates at 3 on the 2-bit instance.
    for (int i = 0; i < 5; i++) step(1, 32'h0000007F, 32'(100 + i), 1, 0);
    chk("sat_cnt", 64'(cnt32), 64'd3);
    step(1, 32'h0000007F, 32'd105, 1, 0);
    step(1, 32'h0000007F, 32'd106, 1, 0);

    // Asynchronous reset mid-stream takes effect immediately.
    in_valid = 1'b1; in_instr = 32'h0000007F; out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_cnt32", 64'(cnt32), 64'd0);
    chk("ar_vld32", 64'(vld32), 64'd0);
    chk("ar_vld64", 64'(vld64), 64'd0);
    chk("ar_imm64", imm64, 64'd0);
    q32.delete(); q64.delete(); mcnt32 = 0; mcnt64 = 0;
    @(negedge clk);
    reset = 1'b0;
    step(0, 32'h0, 32'h0, 1, 0);

    // Random traffic with random backpressure and occasional flush.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      logic [31:0] ins;
      r   = $urandom;
      ins = {r[31:7], opc_tab[$urandom_range(0, 10)]};
      step(logic'($urandom_range(0, 3) != 0), ins, $urandom,
           logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 31) == 0));
    end
    for (int n = 0; n < 3; n++) step(0, 32'h0, 32'h0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
